clk_div_prog: RTL and testbench

Programmable, fully synchronous clock divider for the board clock tree. A single counter runs on the input clock and produces a registered divided clock plus a one-cycle `tick` enable. It replaces fixed ripple chains of divide-by-2 stages. The divisor can be changed at run time without glitches: a new value is staged and only takes effect at the next period boundary.

---
 rtl/clk_div_prog.sv | 98 +++++++++
 tb/tb_clk_div_prog.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable synchronous clock divider: registered divided clock plus one-cycle tick,
// glitch-free run-time divisor change at the period boundary. Optional CLKDIV_DUTY_EN adds duty_val.
module clk_div_prog #(
  parameter int CNT_W       = 19,
  parameter int DEFAULT_DIV = 262144
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0] duty_val,
`endif
  input  logic             div_load,
  output logic             div_pend,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_DIV / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] n_act;
  logic [CNT_W-1:0] n_stg;
  logic [CNT_W-1:0] h_act;
  logic [CNT_W-1:0] h_stg;
  logic [CNT_W-1:0] n_req;
  logic [CNT_W-1:0] h_req;
  logic             wrap;

  // Divisors below 2 cannot form a high and a low phase, so they are clamped to 2.
  assign n_req = (div_val < CNT_W'(2)) ? CNT_W'(2) : div_val;

`ifdef CLKDIV_DUTY_EN
  always_comb begin
    h_req = duty_val;
    if (duty_val == '0)
      h_req = CNT_W'(1);
    else if (duty_val >= n_req)
      h_req = n_req - 1'b1;
  end
`else
  assign h_req = n_req >> 1;
`endif

  assign wrap    = en && (cnt == n_act - 1'b1);
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= DEF_N - 1'b1;
      n_act    <= DEF_N;
      n_stg    <= DEF_N;
      h_act    <= DEF_H;
      h_stg    <= DEF_H;
      div_pend <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (en) begin
        if (wrap) begin
          cnt     <= '0;
          tick    <= 1'b1;
          clk_out <= 1'b1;
          if (div_pend) begin
            n_act <= n_stg;
            h_act <= h_stg;
          end
        end else begin
          cnt     <= cnt_inc;
          tick    <= 1'b0;
          clk_out <= (cnt_inc < h_act);
        end
      end else begin
        tick <= 1'b0;
      end

      // NOTE: non-blocking assignments resolve last-writer-wins, so a load on a
      // wrap edge below overrides the staged-value transfer above for that edge.
      if (div_load) begin
        n_stg <= n_req;
        h_stg <= h_req;
        if (wrap) begin
          n_act    <= n_req;
          h_act    <= h_req;
          div_pend <= 1'b0;
        end else begin
          div_pend <= 1'b1;
        end
      end else if (wrap) begin
        div_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (DEFAULT_DIV shrunk to 10 to keep runs short).
module tb_clk_div_prog;

  localparam int CNT_W = 19;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_pend;
  logic             clk_out;
  logic             tick;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] co, tk, pd;

  clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(10)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_pend (div_pend),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Character i of the string is the expected value after the i-th captured edge.
  function automatic logic [63:0] bits(input string s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++)
      if (s[i] == "1") r[i] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic capture(input int n, output logic [63:0] c, output logic [63:0] t,
                         output logic [63:0] p);
    c = '0;
    t = '0;
    p = '0;
    for (int i = 0; i < n; i++) begin
      step();
      c[i] = clk_out;
      t[i] = tick;
      p[i] = div_pend;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    div_val  = '0;
    div_load = 1'b0;
    step();
    step();
    check("rst_clk_out", 64'(clk_out), 64'd0);
    check("rst_tick", 64'(tick), 64'd0);
    check("rst_div_pend", 64'(div_pend), 64'd0);

    // Default divisor 10: tick on first enabled edge, 5 high / 5 low.
    rst_n = 1'b1;
    en    = 1'b1;
    capture(20, co, tk, pd);
    check("default_clk", co, bits("11111000001111100000"));
    check("default_tick", tk, bits("10000000001000000000"));
    check("default_pend", pd, bits("00000000000000000000"));

    // Load 5 at cycle 2 of a 10-cycle period.
    step();
    check("p3_wrap_tick", 64'(tick), 64'd1);
    step();
    div_val  = 19'd5;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("load5_pend_rise", 64'(div_pend), 64'd1);
    check("load5_clk_still_high", 64'(clk_out), 64'd1);
    capture(17, co, tk, pd);
    check("load5_clk", co, bits("11000001100011000"));
    check("load5_tick", tk, bits("00000001000010000"));
    check("load5_pend", pd, bits("11111110000000000"));

    // Two loads in one period: 7 then 4; only 4 is applied.
    step();
    div_val  = 19'd7;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("load7_pend", 64'(div_pend), 64'd1);
    step();
    div_val  = 19'd4;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("load4_pend", 64'(div_pend), 64'd1);
    capture(13, co, tk, pd);
    check("load4_clk", co, bits("0110011001100"));
    check("load4_tick", tk, bits("0100010001000"));
    check("load4_pend_fall", pd, bits("1000000000000"));

    // Load 0 on a wrap edge: applied directly, no pending flag.
    div_val  = 19'd0;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("load0_wrap_pend", 64'(div_pend), 64'd0);
    check("load0_wrap_tick", 64'(tick), 64'd1);
    capture(6, co, tk, pd);
    check("load0_clk", co, bits("010101"));
    check("load0_tick", tk, bits("010101"));
    check("load0_pend", pd, bits("000000"));

    // Load 1 mid-period: staged, clamps to 2.
    div_val  = 19'd1;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("load1_pend", 64'(div_pend), 64'd1);
    check("load1_clk", 64'(clk_out), 64'd0);
    capture(6, co, tk, pd);
    check("load1_clk_seq", co, bits("101010"));
    check("load1_tick_seq", tk, bits("101010"));
    check("load1_pend_seq", pd, bits("000000"));

    // N=8 with en low for 3 cycles during the high phase.
    div_val  = 19'd8;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("load8_tick", 64'(tick), 64'd1);
    capture(2, co, tk, pd);
    check("pause_pre_clk", co, bits("11"));
    en = 1'b0;
    capture(3, co, tk, pd);
    check("pause_clk", co, bits("111"));
    check("pause_tick", tk, bits("000"));
    en = 1'b1;
    capture(13, co, tk, pd);
    check("pause_post_clk", co, bits("1000011110000"));
    check("pause_post_tick", tk, bits("0000010000000"));

    // Reset with a load pending: outputs drop at once, staged value discarded.
    step();
    div_val  = 19'd3;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("prerst_pend", 64'(div_pend), 64'd1);
    check("prerst_clk", 64'(clk_out), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_clk", 64'(clk_out), 64'd0);
    check("async_rst_tick", 64'(tick), 64'd0);
    check("async_rst_pend", 64'(div_pend), 64'd0);
    step();
    rst_n = 1'b1;
    capture(20, co, tk, pd);
    check("post_rst_clk", co, bits("11111000001111100000"));
    check("post_rst_tick", tk, bits("10000000001000000000"));
    check("post_rst_pend", pd, bits("00000000000000000000"));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
